// File: rtl/csr_commit_unit_pkg.sv
// Shared types, constants and the side-effect CSR decode for the CSR commit unit.
package csr_commit_unit_pkg;

    localparam int unsigned XLEN = 64;

    typedef enum logic [1:0] {
        CSR_READ  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } fu_op;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RSP   = 2'd2,
        FLUSH = 2'd3
    } csr_commit_state_e;

    // Address bits [11:10] == 2'b11 mark the read-only CSR space.
    localparam logic [1:0] CSR_RO_ADDR_MSB = 2'b11;

    // CSRs whose update changes translation, FP or machine state and so needs a pipeline flush.
    function automatic logic is_side_effect_csr(input logic [11:0] addr);
        logic w_hit;
        w_hit = 1'b0;
        case (addr)
            12'h001, 12'h002, 12'h003,          // fflags, frm, fcsr
            12'h180,                            // satp
            12'h100, 12'h300, 12'h301: w_hit = 1'b1;  // sstatus, mstatus, misa
            default: w_hit = (addr >= 12'h3A0) && (addr <= 12'h3EF);  // pmpcfg*, pmpaddr*
        endcase
        return w_hit;
    endfunction

endpackage

// File: rtl/csr_commit_perf_cnt.sv
// Saturating 32-bit event counter counting CSR commit pulses.
module csr_commit_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= 32'd0;
        end else if (inc_i && (r_count != 32'hFFFF_FFFF)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/csr_commit_unit.sv
// Commit-side CSR read-modify-write sequencer: IDLE -> REQ -> RSP (-> FLUSH) -> IDLE.
// Optional macro CSR_COMMIT_PERF_EN adds the perf_csr_commits_o saturating counter.
module csr_commit_unit
    import csr_commit_unit_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                commit_valid_i,
    output logic                commit_ready_o,
    input  fu_op                commit_op_i,
    input  logic [11:0]         commit_addr_i,
    input  logic [XLEN-1:0]     commit_wdata_i,
    output logic                csr_req_o,
    input  logic                csr_gnt_i,
    output fu_op                csr_op_o,
    output logic [11:0]         csr_addr_o,
    output logic [XLEN-1:0]     csr_wdata_o,
    input  logic                csr_rvalid_i,
    input  logic [XLEN-1:0]     csr_rdata_i,
    input  logic                csr_ex_i,
    output logic                csr_commit_o,
    output logic                wb_valid_o,
    output logic [XLEN-1:0]     wb_data_o,
    output logic                wb_ex_o,
    output logic [XLEN-1:0]     wb_tval_o,
    output logic                flush_req_o,
    input  logic                flush_ack_i,
`ifdef CSR_COMMIT_PERF_EN
    output logic [31:0]         perf_csr_commits_o,
`endif
    output csr_commit_state_e   dbg_state_o
);

    csr_commit_state_e r_state;
    logic              r_commit_ready;
    fu_op              r_op;
    logic [11:0]       r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic              r_csr_req;
    logic              r_csr_commit;
    logic              r_wb_valid;
    logic [XLEN-1:0]   r_wb_data;
    logic              r_wb_ex;
    logic [XLEN-1:0]   r_wb_tval;
    logic              r_flush_req;

    logic              w_ro_violation;
    logic              w_needs_flush;

    assign w_ro_violation = (commit_addr_i[11:10] == CSR_RO_ADDR_MSB) && (commit_op_i == CSR_WRITE);
    assign w_needs_flush  = is_side_effect_csr(r_addr) && (r_op != CSR_READ);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_commit_ready <= 1'b1;
            r_op           <= CSR_READ;
            r_addr         <= 12'd0;
            r_wdata        <= '0;
            r_csr_req      <= 1'b0;
            r_csr_commit   <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_data      <= '0;
            r_wb_ex        <= 1'b0;
            r_wb_tval      <= '0;
            r_flush_req    <= 1'b0;
        end else begin
            r_csr_commit   <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_ex        <= 1'b0;
            r_commit_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Ready rises one cycle after re-entering IDLE, spacing commits by 4 cycles.
                    r_commit_ready <= 1'b1;
                    if (r_commit_ready && commit_valid_i && !flush_i) begin
                        r_op    <= commit_op_i;
                        r_addr  <= commit_addr_i;
                        r_wdata <= commit_wdata_i;
                        if (w_ro_violation) begin
                            r_wb_valid <= 1'b1;
                            r_wb_ex    <= 1'b1;
                            r_wb_data  <= '0;
                            r_wb_tval  <= {{(XLEN-12){1'b0}}, commit_addr_i};
                        end else begin
                            r_state        <= REQ;
                            r_csr_req      <= 1'b1;
                            r_commit_ready <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (csr_gnt_i) begin
                        r_csr_req <= 1'b0;
                        r_state   <= RSP;
                    end else if (flush_i) begin
                        r_csr_req <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                RSP: begin
                    // A flush here cannot cancel the access; it only hides the writeback.
                    if (csr_rvalid_i) begin
                        r_wb_valid   <= !flush_i;
                        r_wb_ex      <= csr_ex_i && !flush_i;
                        r_wb_data    <= csr_rdata_i;
                        r_wb_tval    <= csr_ex_i ? {{(XLEN-12){1'b0}}, r_addr} : '0;
                        r_csr_commit <= !csr_ex_i;
                        if (!csr_ex_i && !flush_i && w_needs_flush) begin
                            r_state     <= FLUSH;
                            r_flush_req <= 1'b1;
                        end else begin
                            r_state     <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_ack_i || flush_i) begin
                        r_flush_req <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign commit_ready_o = r_commit_ready;
    assign csr_req_o      = r_csr_req;
    assign csr_op_o       = r_op;
    assign csr_addr_o     = r_addr;
    assign csr_wdata_o    = r_wdata;
    assign csr_commit_o   = r_csr_commit;
    assign wb_valid_o     = r_wb_valid;
    assign wb_data_o      = r_wb_data;
    assign wb_ex_o        = r_wb_ex;
    assign wb_tval_o      = r_wb_tval;
    assign flush_req_o    = r_flush_req;
    assign dbg_state_o    = r_state;

`ifdef CSR_COMMIT_PERF_EN
    csr_commit_perf_cnt u_perf_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (r_csr_commit),
        .count_o (perf_csr_commits_o)
    );
`endif

endmodule

// File: tb/tb_csr_commit_unit.sv
// Directed bench for csr_commit_unit: inline timing checks plus a scoreboard of commit/writeback events.
module tb_csr_commit_unit;
  import csr_commit_unit_pkg::*;

  localparam int EW = 3 + 64 + 64;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  logic              commit_valid_i;
  logic              commit_ready_o;
  fu_op              commit_op_i;
  logic [11:0]       commit_addr_i;
  logic [XLEN-1:0]   commit_wdata_i;
  logic              csr_req_o;
  logic              csr_gnt_i;
  fu_op              csr_op_o;
  logic [11:0]       csr_addr_o;
  logic [XLEN-1:0]   csr_wdata_o;
  logic              csr_rvalid_i;
  logic [XLEN-1:0]   csr_rdata_i;
  logic              csr_ex_i;
  logic              csr_commit_o;
  logic              wb_valid_o;
  logic [XLEN-1:0]   wb_data_o;
  logic              wb_ex_o;
  logic [XLEN-1:0]   wb_tval_o;
  logic              flush_req_o;
  logic              flush_ack_i;
`ifdef CSR_COMMIT_PERF_EN
  logic [31:0]       perf_csr_commits_o;
`endif
  csr_commit_state_e dbg_state_o;

  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];

  csr_commit_unit dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .commit_valid_i (commit_valid_i),
    .commit_ready_o (commit_ready_o),
    .commit_op_i    (commit_op_i),
    .commit_addr_i  (commit_addr_i),
    .commit_wdata_i (commit_wdata_i),
    .csr_req_o      (csr_req_o),
    .csr_gnt_i      (csr_gnt_i),
    .csr_op_o       (csr_op_o),
    .csr_addr_o     (csr_addr_o),
    .csr_wdata_o    (csr_wdata_o),
    .csr_rvalid_i   (csr_rvalid_i),
    .csr_rdata_i    (csr_rdata_i),
    .csr_ex_i       (csr_ex_i),
    .csr_commit_o   (csr_commit_o),
    .wb_valid_o     (wb_valid_o),
    .wb_data_o      (wb_data_o),
    .wb_ex_o        (wb_ex_o),
    .wb_tval_o      (wb_tval_o),
    .flush_req_o    (flush_req_o),
    .flush_ack_i    (flush_ack_i),
`ifdef CSR_COMMIT_PERF_EN
    .perf_csr_commits_o (perf_csr_commits_o),
`endif
    .dbg_state_o    (dbg_state_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] ev(input logic c, input logic v, input logic e,
                                       input logic [63:0] tval, input logic [63:0] data);
    return {c, v, e, tval, data};
  endfunction

  // Drivers
  task automatic issue(input fu_op op, input logic [11:0] addr, input logic [63:0] wdata);
    commit_valid_i = 1'b1;
    commit_op_i    = op;
    commit_addr_i  = addr;
    commit_wdata_i = wdata;
    tick();
    commit_valid_i = 1'b0;
  endtask

  task automatic grant_then_respond(input logic [63:0] rdata, input logic ex, input logic fl);
    csr_gnt_i = 1'b1;
    tick();
    csr_gnt_i    = 1'b0;
    csr_rvalid_i = 1'b1;
    csr_rdata_i  = rdata;
    csr_ex_i     = ex;
    flush_i      = fl;
    tick();
    csr_rvalid_i = 1'b0;
    csr_ex_i     = 1'b0;
    flush_i      = 1'b0;
  endtask

  // Scoreboard monitor: every commit/writeback event must match the head of exp_q.
  always @(negedge clk_i) begin
    if (!rst_i && (csr_commit_o || wb_valid_o || wb_ex_o)) begin
      logic [EW-1:0] act;
      logic [EW-1:0] exp;
      act = {csr_commit_o, wb_valid_o, wb_ex_o,
             wb_ex_o ? wb_tval_o : 64'd0,
             wb_valid_o ? wb_data_o : 64'd0};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got commit=%0b wb_valid=%0b wb_ex=%0b data=0x%0h with nothing expected",
                 csr_commit_o, wb_valid_o, wb_ex_o, wb_data_o);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          fails++;
          $display("FAIL wb_event: got c/v/e=%0b%0b%0b tval=0x%0h data=0x%0h expected c/v/e=%0b%0b%0b tval=0x%0h data=0x%0h",
                   act[EW-1], act[EW-2], act[EW-3], act[127:64], act[63:0],
                   exp[EW-1], exp[EW-2], exp[EW-3], exp[127:64], exp[63:0]);
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; commit_valid_i = 1'b0; commit_op_i = CSR_READ;
    commit_addr_i = 12'd0; commit_wdata_i = 64'd0; csr_gnt_i = 1'b0; csr_rvalid_i = 1'b0;
    csr_rdata_i = 64'd0; csr_ex_i = 1'b0; flush_ack_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();

    // Reset state
    check("rst_ready", 64'(commit_ready_o), 64'd1);
    check("rst_req", 64'(csr_req_o), 64'd0);
    check("rst_flush_req", 64'(flush_req_o), 64'd0);
    check("rst_state", 64'(dbg_state_o), 64'(IDLE));
`ifdef CSR_COMMIT_PERF_EN
    check("rst_perf", 64'(perf_csr_commits_o), 64'd0);
`endif

    // mscratch write: accept t0, grant t1, rvalid t2, writeback t3, ready t4
    issue(CSR_WRITE, 12'h340, 64'h55);
    check("w_t1_req", 64'(csr_req_o), 64'd1);
    check("w_t1_ready_low", 64'(commit_ready_o), 64'd0);
    check("w_t1_addr", 64'(csr_addr_o), 64'h340);
    check("w_t1_wdata", csr_wdata_o, 64'h55);
    check("w_t1_op", 64'(csr_op_o), 64'(CSR_WRITE));
    exp_q.push_back(ev(1'b1, 1'b1, 1'b0, 64'd0, 64'h11));
    grant_then_respond(64'h11, 1'b0, 1'b0);
    check("w_t3_flush_req", 64'(flush_req_o), 64'd0);
    check("w_t3_ready_low", 64'(commit_ready_o), 64'd0);
    tick();
    check("w_t4_ready", 64'(commit_ready_o), 64'd1);

    // Write to read-only cycle CSR: exception at t1, no request, no commit
    exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 64'hC00, 64'd0));
    issue(CSR_WRITE, 12'hC00, 64'h1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ro_no_req_c%0d", i), 64'(csr_req_o), 64'd0);
      tick();
    end
    check("ro_state", 64'(dbg_state_o), 64'(IDLE));

    // CSR_SET to satp: flush_req held 3 cycles until ack
    issue(CSR_SET, 12'h180, 64'h8);
    exp_q.push_back(ev(1'b1, 1'b1, 1'b0, 64'd0, 64'hABC));
    grant_then_respond(64'hABC, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("satp_flush_req_c%0d", i), 64'(flush_req_o), 64'd1);
      if (i == 2) flush_ack_i = 1'b1;
      tick();
    end
    flush_ack_i = 1'b0;
    check("satp_flush_req_drop", 64'(flush_req_o), 64'd0);
    check("satp_state_idle", 64'(dbg_state_o), 64'(IDLE));
    tick();

    // Grant withheld; flush in cycle 3 of REQ drops the request silently
    issue(CSR_CLEAR, 12'h341, 64'h1234);
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("hold_req_c%0d", i), 64'(csr_req_o), 64'd1);
      check($sformatf("hold_addr_c%0d", i), 64'(csr_addr_o), 64'h341);
      check($sformatf("hold_wdata_c%0d", i), csr_wdata_o, 64'h1234);
      if (i == 3) flush_i = 1'b1;
      tick();
    end
    flush_i = 1'b0;
    check("hold_req_dropped", 64'(csr_req_o), 64'd0);
    check("hold_state_idle", 64'(dbg_state_o), 64'(IDLE));
    tick();
    tick();

    // CSR file rejects a read of dcsr
    issue(CSR_READ, 12'h7B0, 64'd0);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 64'h7B0, 64'hDEAD));
    grant_then_respond(64'hDEAD, 1'b1, 1'b0);
    check("ex_flush_req", 64'(flush_req_o), 64'd0);
    check("ex_state", 64'(dbg_state_o), 64'(IDLE));
    tick();

    // Flush during RSP: commit still pulses, writeback suppressed
    issue(CSR_WRITE, 12'h340, 64'h7);
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 64'd0, 64'd0));
    grant_then_respond(64'h22, 1'b0, 1'b1);
    check("rspfl_state", 64'(dbg_state_o), 64'(IDLE));
    tick();
`ifdef CSR_COMMIT_PERF_EN
    check("perf_count", 64'(perf_csr_commits_o), 64'd3);
`endif

    // Reset mid-operation discards the pending grant/response
    issue(CSR_WRITE, 12'h340, 64'h9);
    check("mid_req", 64'(csr_req_o), 64'd1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_state", 64'(dbg_state_o), 64'(IDLE));
    check("mid_rst_req", 64'(csr_req_o), 64'd0);
    check("mid_rst_ready", 64'(commit_ready_o), 64'd1);
`ifdef CSR_COMMIT_PERF_EN
    check("mid_rst_perf", 64'(perf_csr_commits_o), 64'd0);
`endif
    csr_gnt_i = 1'b1;
    tick();
    rst_i = 1'b0;
    csr_gnt_i = 1'b0;
    csr_rvalid_i = 1'b1;
    csr_rdata_i = 64'h33;
    tick();
    csr_rvalid_i = 1'b0;
    check("mid_after_state", 64'(dbg_state_o), 64'(IDLE));
    repeat (3) tick();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/csr_commit_unit.md
# csr_commit_unit

Commit-side consumer of the single-entry CSR address buffer. When the instruction at the scoreboard head is a CSR op, this block accepts the buffered address and operand, performs the read-modify-write handshake with the CSR register file, and returns writeback data or an exception. It pulses the commit strobe back to the buffer so the buffer can free its entry, and requests a pipeline flush for side-effecting CSRs.

## Interface
- No parameters.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: pipeline flush.
- `commit_valid_i` in 1: the head instruction is a CSR op that is ready to commit.
- `commit_ready_o` out 1: the unit can accept a commit (high only in IDLE).
- `commit_op_i` in `fu_op`: CSR_READ, CSR_WRITE, CSR_SET or CSR_CLEAR.
- `commit_addr_i` in 12: CSR address from the buffer.
- `commit_wdata_i` in `riscv::xlen_t`: operand from the buffer's result path.
- `csr_req_o` out 1: request to the CSR file.
- `csr_gnt_i` in 1: grant from the CSR file.
- `csr_op_o` out `fu_op`: operation sent to the CSR file.
- `csr_addr_o` out 12: address sent to the CSR file.
- `csr_wdata_o` out xlen: write data sent to the CSR file.
- `csr_rvalid_i` in 1: response valid (one-cycle pulse, at least 1 cycle after grant).
- `csr_rdata_i` in xlen: read data (old CSR value).
- `csr_ex_i` in 1: the CSR file rejected the access (privilege or nonexistent CSR).
- `csr_commit_o` out 1: one-cycle pulse that frees the buffer entry.
- `wb_valid_o` out 1: writeback valid (pulse).
- `wb_data_o` out xlen: writeback data.
- `wb_ex_o` out 1: writeback carries an illegal-instruction exception.
- `wb_tval_o` out xlen: trap value (zero-extended address) when `wb_ex_o` is set.
- `flush_req_o` out 1: request a pipeline flush for a side-effecting CSR.
- `flush_ack_i` in 1: the flush request has been taken.

## Operation
- FSM states: IDLE, REQ, RSP, FLUSH. Reset state is IDLE.
- Reset values: all outputs 0, except `commit_ready_o` = 1.
- **IDLE:** on `commit_valid_i`, latch op, addr and wdata.
  - Read-only violation: if `addr[11:10]==2'b11` and op is CSR_WRITE, do not issue a request. Next cycle: `wb_valid_o`=1, `wb_ex_o`=1, `wb_tval_o`=addr, no `csr_commit_o`. Stay in IDLE.
  - Otherwise go to REQ.
- **REQ:** `csr_req_o`=1 with the latched fields held stable until `csr_gnt_i`, then go to RSP.
  - `flush_i` in REQ before the grant drops the op and returns to IDLE. No request is left outstanding and no outputs pulse.
- **RSP:** wait for `csr_rvalid_i`. Next cycle:
  - `wb_valid_o`=1 and `wb_data_o`=`csr_rdata_i`.
  - `wb_ex_o`=`csr_ex_i`; if set, `wb_tval_o`=addr.
  - `csr_commit_o`=1 only if `csr_ex_i`=0.
  - Next state: FLUSH if there is no exception and `is_side_effect_csr(addr)` is true and op≠CSR_READ; otherwise IDLE.
  - `flush_i` during RSP does not abort, because the access is already architectural. The response is still consumed and `csr_commit_o` still pulses, but `wb_valid_o` is suppressed.
- **FLUSH:** `flush_req_o`=1 until `flush_ack_i`, then go to IDLE. `flush_i` in this state also returns to IDLE.
- `csr_commit_o`, `wb_valid_o` and `wb_ex_o` are registered pulses and are never asserted for more than 1 cycle.

## Timing
- Minimum accept-to-writeback latency is 3 cycles: accept at t0, request and grant at t1, rvalid at t2, writeback and commit at t3.
- `commit_ready_o` is low from t0+1 until the cycle after the unit returns to IDLE. Back-to-back CSR commits are therefore spaced by at least 4 cycles.
- Read-only violation: writeback exception at t0+1.
- Reset asserted mid-operation returns the FSM to IDLE immediately; a pending grant or response is discarded.

## Configuration
- `CSR_COMMIT_PERF_EN` defined:
  - Adds output `perf_csr_commits_o` (32 bits), a counter that increments on each `csr_commit_o` pulse and saturates at 0xFFFF_FFFF.
  - It resets to 0 and is not cleared by `flush_i`.
- Undefined: the port and the counter are absent.

## Structure
- `ariane_pkg` gets:
  - the `csr_commit_state_e` enum;
  - the `is_side_effect_csr(logic [11:0])` function, true for fcsr, frm, fflags, satp, mstatus, sstatus, misa, and the pmpcfg/pmpaddr ranges;
  - a `CSR_RO_ADDR_MSB=2'b11` constant.
- One sub-module, `csr_commit_perf_cnt`, holds the saturating counter and is instantiated only under the macro.

## Test plan
- Write to mscratch (0x340, CSR_WRITE, wdata 0x55, CSR file returns 0x11) with `csr_gnt_i` at t1 and `csr_rvalid_i` at t2:
  - At t3: `wb_data_o`=0x11, `csr_commit_o`=1, `flush_req_o`=0.
  - At t4: `commit_ready_o`=1.
- CSR_WRITE to cycle (0xC00):
  - At t1: `wb_ex_o`=1, `wb_tval_o`=0xC00.
  - `csr_req_o` never rises and `csr_commit_o` stays 0.
- CSR_SET to satp (0x180):
  - After the writeback, `flush_req_o` holds for 3 cycles until `flush_ack_i`, then the FSM is in IDLE.
- `csr_gnt_i` withheld for 5 cycles:
  - `csr_req_o`, `csr_addr_o` and `csr_wdata_o` stay stable throughout.
  - `flush_i` at cycle 3 drops `csr_req_o` the next cycle, and no `wb_valid_o` follows.
- `csr_ex_i`=1 on a CSR_READ of 0x7B0:
  - `wb_ex_o`=1, `wb_tval_o`=0x7B0, `csr_commit_o`=0.
- `flush_i` asserted during RSP:
  - `csr_commit_o` pulses, `wb_valid_o` stays 0.
  - With `CSR_COMMIT_PERF_EN` defined, the counter increments by 1.
